// File: rtl/shift_pkg.sv
// Shared types and encodings for the multi-cycle shift sequencer.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    LOGICAL,
    ARITH,
    ROTATE,
    RSVD
  } shift_mode_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shift_row.sv
// WIDTH-bit register built from per-bit hold / shift-left / shift-right cells,
// with a parallel load path for command capture.
module shift_row
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic             fill_msb_i,
  input  logic             fill_lsb_i,
  output logic [WIDTH-1:0] q_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic from_lo;
    logic from_hi;
    logic bit_d;
    logic bit_q;

    // Edge cells take the boundary fill instead of a neighbour.
    if (i == 0) begin : g_lsb
      assign from_lo = fill_lsb_i;
    end else begin : g_lo
      assign from_lo = q_o[i-1];
    end

    if (i == WIDTH - 1) begin : g_msb
      assign from_hi = fill_msb_i;
    end else begin : g_hi
      assign from_hi = q_o[i+1];
    end

    always_comb begin
      bit_d = bit_q;
      if (load_i) begin
        bit_d = load_data_i[i];
      end else if (en_i) begin
        bit_d = (dir_i == DIR_LEFT) ? from_lo : from_hi;
      end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        bit_q <= 1'b0;
      end else begin
        bit_q <= bit_d;
      end
    end

    assign q_o[i] = bit_q;
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift unit: accepts one command, shifts one bit per clock
// through a shift_row, then pulses done_o for one cycle.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [AMT_W-1:0] amount_i,
  input  logic             dir_i,
  input  logic [1:0]       mode_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] data_o
);

  state_t      state_q, state_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic        dir_q, dir_d;
  shift_mode_t mode_q, mode_d;

  logic [AMT_W-1:0] amt_sat;
  logic             load;
  logic             shift_en;
  logic             fill_msb;
  logic             fill_lsb;
  logic [WIDTH-1:0] row_q;

  // Only reachable when WIDTH is not a power of two.
  always_comb begin
    amt_sat = amount_i;
    if ({1'b0, amount_i} > (AMT_W + 1)'(WIDTH - 1)) begin
      amt_sat = AMT_W'(WIDTH - 1);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    mode_d   = mode_q;
    load     = 1'b0;
    shift_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          load    = 1'b1;
          cnt_d   = amt_sat;
          dir_d   = dir_i;
          mode_d  = shift_mode_t'(mode_i);
          state_d = (amt_sat != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == AMT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    fill_msb = 1'b0;
    fill_lsb = 1'b0;
    unique case (mode_q)
      ARITH: begin
        fill_msb = row_q[WIDTH-1];
      end
      ROTATE: begin
        fill_msb = row_q[0];
        fill_lsb = row_q[WIDTH-1];
      end
      default: begin
        fill_msb = 1'b0;
        fill_lsb = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_RIGHT;
      mode_q  <= LOGICAL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
    end
  end

  shift_row #(
    .WIDTH(WIDTH)
  ) u_row (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (load),
    .load_data_i(data_i),
    .en_i       (shift_en),
    .dir_i      (dir_q),
    .fill_msb_i (fill_msb),
    .fill_lsb_i (fill_lsb),
    .q_o        (row_q)
  );

  assign ready_o = (state_q == IDLE);
  assign busy_o  = (state_q == SHIFT);
  assign done_o  = (state_q == DONE);
  assign data_o  = row_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed and randomized checks of shift_sequencer against a whole-shift
// arithmetic reference model.
module tb_shift_sequencer;

  localparam int unsigned W = 8;

  logic         clk_i;
  logic         rst_n_i;
  logic         start_i;
  logic [W-1:0] data_i;
  logic [2:0]   amount_i;
  logic         dir_i;
  logic [1:0]   mode_i;
  logic         ready_o;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] data_o;

  int checks   = 0;
  int failures = 0;

  shift_sequencer #(
    .WIDTH(W)
  ) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .start_i (start_i),
    .data_i  (data_i),
    .amount_i(amount_i),
    .dir_i   (dir_i),
    .mode_i  (mode_i),
    .ready_o (ready_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .data_o  (data_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Final result of an n-bit shift, computed in one step.
  function automatic logic [W-1:0] model(input logic [W-1:0] x, input int unsigned n,
                                         input logic dr, input logic [1:0] md);
    logic signed [W-1:0] s;
    logic [W-1:0] r;
    s = x;
    if (dr) begin
      if (md == 2'b10) r = (x << n) | (x >> (W - n));
      else             r = x << n;
    end else begin
      if (md == 2'b01)      r = s >>> n;
      else if (md == 2'b10) r = (x >> n) | (x << (W - n));
      else                  r = x >> n;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_cmd(input logic [W-1:0] d, input int unsigned n,
                         input logic dr, input logic [1:0] md);
    logic [W-1:0] exp;
    exp = model(d, n, dr, md);
    check("ready_c0", ready_o, 1);
    start_i  = 1'b1;
    data_i   = d;
    amount_i = 3'(n);
    dir_i    = dr;
    mode_i   = md;
    next_cycle();
    start_i  = 1'b0;
    data_i   = W'($urandom);
    amount_i = 3'($urandom);
    for (int unsigned k = 1; k <= n + 1; k++) begin
      check("busy", busy_o, 32'(k <= n));
      check("done", done_o, 32'(k == n + 1));
      check("ready_mid", ready_o, 0);
      if (k == n + 1) check("result", data_o, exp);
      next_cycle();
    end
    check("ready_after", ready_o, 1);
    check("result_held", data_o, exp);
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         da, db;
    logic [1:0]   ma, mb;

    rst_n_i  = 1'b1;
    start_i  = 1'b0;
    data_i   = '0;
    amount_i = '0;
    dir_i    = 1'b0;
    mode_i   = 2'b00;
    #1 rst_n_i = 1'b0;
    #1;
    check("rst_ready", ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_data", data_o, 0);
    next_cycle();
    next_cycle();
    #3 rst_n_i = 1'b1;

    // Directed scenarios
    run_cmd(8'hB4, 3, 1'b0, 2'b00);
    check("lsr_value", data_o, 8'h16);
    run_cmd(8'hB4, 2, 1'b0, 2'b01);
    check("asr_value", data_o, 8'hED);
    run_cmd(8'hB4, 2, 1'b0, 2'b11);
    check("rsvd_value", data_o, 8'h2D);
    run_cmd(8'h81, 7, 1'b1, 2'b10);
    check("rol7_value", data_o, 8'hC0);
    run_cmd(8'h81, 1, 1'b1, 2'b10);
    check("rol1_value", data_o, 8'h03);
    run_cmd(8'h5A, 0, 1'b0, 2'b00);
    check("zero_value", data_o, 8'h5A);
    run_cmd(8'h96, 3, 1'b1, 2'b01);
    run_cmd(8'h96, 5, 1'b0, 2'b10);

    // start_i held high through an entire command
    a = W'($urandom); da = 1'($urandom); ma = 2'($urandom);
    b = W'($urandom); db = 1'($urandom); mb = 2'($urandom);
    check("hold_ready_c0", ready_o, 1);
    start_i = 1'b1; data_i = a; amount_i = 3'd4; dir_i = da; mode_i = ma;
    next_cycle();
    for (int unsigned k = 1; k <= 5; k++) begin
      data_i = W'($urandom); amount_i = 3'($urandom);
      dir_i = 1'($urandom); mode_i = 2'($urandom);
      check("hold_busy", busy_o, 32'(k <= 4));
      check("hold_done", done_o, 32'(k == 5));
      check("hold_ready", ready_o, 0);
      if (k == 5) check("hold_result", data_o, model(a, 4, da, ma));
      next_cycle();
    end
    check("hold_ready_c6", ready_o, 1);
    data_i = b; amount_i = 3'd2; dir_i = db; mode_i = mb;
    next_cycle();
    start_i = 1'b0;
    for (int unsigned k = 7; k <= 9; k++) begin
      check("hold2_busy", busy_o, 32'(k <= 8));
      check("hold2_done", done_o, 32'(k == 9));
      if (k == 9) check("hold2_result", data_o, model(b, 2, db, mb));
      next_cycle();
    end
    check("hold2_ready", ready_o, 1);

    // Asynchronous reset in the middle of a 6-step shift
    start_i = 1'b1; data_i = 8'hA7; amount_i = 3'd6; dir_i = 1'b1; mode_i = 2'b10;
    next_cycle();
    start_i = 1'b0;
    next_cycle();
    check("pre_rst_busy", busy_o, 1);
    #2 rst_n_i = 1'b0;
    #1;
    check("arst_data", data_o, 0);
    check("arst_ready", ready_o, 1);
    check("arst_busy", busy_o, 0);
    check("arst_done", done_o, 0);
    next_cycle();
    #3 rst_n_i = 1'b1;
    for (int unsigned k = 0; k < 8; k++) begin
      next_cycle();
      check("post_rst_done", done_o, 0);
      check("post_rst_ready", ready_o, 1);
      check("post_rst_data", data_o, 0);
    end
    run_cmd(8'h3C, 6, 1'b0, 2'b01);

    // Randomized commands
    for (int unsigned i = 0; i < 40; i++) begin
      run_cmd(W'($urandom), $urandom_range(0, 7), 1'($urandom), 2'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
